// File: rtl/hbm_delay_pck.sv
// Shared types, widths and helpers for the HBM delay-release path.
package hbm_delay_pck;

  localparam int TIMERw         = 10;
  localparam int DELAY_FIFO_NUM = 2;
  localparam int NOC_DATA_WIDTH = 32;

  // Bit 1 of the flit type marks a head flit and bit 0 marks a tail flit.
  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_t;

  // One delay-FIFO entry: the flit type, its release time and the flit payload.
  typedef struct packed {
    flit_type_t                ftype;
    logic [TIMERw-1:0]         exp_time;
    logic [NOC_DATA_WIDTH-1:0] flit;
  } fifo_dat_t;

  localparam int FIFO_DW = $bits(fifo_dat_t);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rel_state_t;

  // The timer wraps, so the sign bit of (timer - exp_time) tells whether the entry
  // is due: it counts as expired when due or late by less than half the timer range.
  function automatic logic hbm_expired(input logic [TIMERw-1:0] timer,
                                       input logic [TIMERw-1:0] exp_time);
    logic [TIMERw-1:0] diff;
    diff = timer - exp_time;
    return ~diff[TIMERw-1];
  endfunction

endpackage

// File: rtl/hbm_rr_arb.sv
// Round-robin arbiter: one-hot grant among the requesters, search starts after the last grant.
module hbm_rr_arb import hbm_delay_pck::*; #(
  parameter int  N    = DELAY_FIFO_NUM,
  localparam int PTRW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [PTRW-1:0] gnt_idx,
  output logic            any_gnt
);

  logic [PTRW-1:0] ptr_q;
  logic [PTRW-1:0] idx;

  // Walk the requesters starting at the pointer and grant the first one found.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTRW'((int'(ptr_q) + i) % N);
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any_gnt  = 1'b1;
      end
    end
  end

  // The pointer only moves when the grant is actually taken by the caller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en && any_gnt) begin
      ptr_q <= (gnt_idx == PTRW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/hbm_delay_release.sv
// Drains delayed packets from the delay FIFOs once their head is due and forwards
// them flit by flit to the NoC through a single output register.
module hbm_delay_release
  import hbm_delay_pck::fifo_dat_t, hbm_delay_pck::FIFO_DW,
         hbm_delay_pck::NOC_DATA_WIDTH, hbm_delay_pck::DELAY_FIFO_NUM,
         hbm_delay_pck::rel_state_t, hbm_delay_pck::IDLE, hbm_delay_pck::SEND,
         hbm_delay_pck::hbm_expired;
#(
  parameter int FIFO_NUM = DELAY_FIFO_NUM,
  parameter int TIMERw   = hbm_delay_pck::TIMERw
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [TIMERw-1:0]                  timer_i,
  input  logic [FIFO_NUM-1:0][FIFO_DW-1:0]   fifo_dat_i,
  input  logic [FIFO_NUM-1:0]                fifo_empty_i,
  output logic [FIFO_NUM-1:0]                fifo_rd_o,
  output logic                               noc_valid_o,
  output logic [NOC_DATA_WIDTH-1:0]          noc_data_o,
  input  logic                               noc_ready_i
);

  localparam int PTRW = (FIFO_NUM > 1) ? $clog2(FIFO_NUM) : 1;

  fifo_dat_t                 head [FIFO_NUM];
  logic [FIFO_NUM-1:0]       req;
  logic [FIFO_NUM-1:0]       gnt;
  logic [PTRW-1:0]           gnt_idx;
  logic                      any_gnt;
  logic                      arb_en;
  rel_state_t                state_q, state_d;
  logic [PTRW-1:0]           lock_q, lock_d;
  logic                      out_free;
  logic                      load;
  logic [NOC_DATA_WIDTH-1:0] load_flit;
  logic [FIFO_NUM-1:0]       rd;
  logic                      drop_flit;

  assign out_free = ~noc_valid_o | noc_ready_i;

  // A FIFO asks for service when its head is a due head flit, or when it shows a
  // stray non-head flit that has to be thrown away.
  always_comb begin
    for (int i = 0; i < FIFO_NUM; i++) begin
      head[i] = fifo_dat_i[i];
      req[i]  = ~fifo_empty_i[i] &
                (~head[i].ftype[1] | hbm_expired(timer_i, head[i].exp_time));
    end
  end

  hbm_rr_arb #(
    .N(FIFO_NUM)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Next state, pop strobes and output load: IDLE picks a packet, SEND drains the locked FIFO.
  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    rd        = '0;
    load      = 1'b0;
    load_flit = '0;
    arb_en    = 1'b0;
    drop_flit = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_gnt) begin
          if (!head[gnt_idx].ftype[1]) begin
            rd        = gnt;
            arb_en    = 1'b1;
            drop_flit = 1'b1;
          end else if (out_free) begin
            rd        = gnt;
            arb_en    = 1'b1;
            load      = 1'b1;
            load_flit = head[gnt_idx].flit;
            lock_d    = gnt_idx;
            if (!head[gnt_idx].ftype[0]) begin
              state_d = SEND;
            end
          end
        end
      end
      SEND: begin
        if (!fifo_empty_i[lock_q] && out_free) begin
          rd[lock_q] = 1'b1;
          load       = 1'b1;
          load_flit  = head[lock_q].flit;
          if (head[lock_q].ftype[0]) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pops are suppressed while reset is held so the FIFO owner sees a clean reset.
  assign fifo_rd_o = rd & {FIFO_NUM{~rst}};

  // State and packet lock register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // Output register: loads on a pop, clears once accepted, holds while back-pressured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noc_valid_o <= 1'b0;
      noc_data_o  <= '0;
    end else if (load) begin
      noc_valid_o <= 1'b1;
      noc_data_o  <= load_flit;
    end else if (noc_ready_i) begin
      noc_valid_o <= 1'b0;
    end
  end

  a_no_stray_flit: assert property (@(posedge clk) disable iff (rst) !drop_flit);
  a_pop_onehot:    assert property (@(posedge clk) disable iff (rst) $onehot0(fifo_rd_o));
  a_pop_nonempty:  assert property (@(posedge clk) disable iff (rst) (fifo_rd_o & fifo_empty_i) == '0);

endmodule

// File: tb/tb_hbm_delay_release.sv
// Directed bench for hbm_delay_release with two show-ahead FIFO models and an output monitor.
module tb_hbm_delay_release;
  import hbm_delay_pck::*;

  logic                                  clk = 1'b0;
  logic                                  rst;
  logic [TIMERw-1:0]                     timer_i;
  logic [DELAY_FIFO_NUM-1:0][FIFO_DW-1:0] fifo_dat_i;
  logic [DELAY_FIFO_NUM-1:0]             fifo_empty_i;
  logic [DELAY_FIFO_NUM-1:0]             fifo_rd_o;
  logic                                  noc_valid_o;
  logic [NOC_DATA_WIDTH-1:0]             noc_data_o;
  logic                                  noc_ready_i;

  int checks   = 0;
  int failures = 0;
  int bad_pops = 0;
  int hold_err = 0;

  logic [FIFO_DW-1:0]        q0 [$];
  logic [FIFO_DW-1:0]        q1 [$];
  logic [NOC_DATA_WIDTH-1:0] acc [$];
  logic [1:0]                rd_cap = '0;
  logic                      prev_stall = 1'b0;
  logic [NOC_DATA_WIDTH-1:0] prev_data = '0;

  hbm_delay_release dut (
    .clk          (clk),
    .rst          (rst),
    .timer_i      (timer_i),
    .fifo_dat_i   (fifo_dat_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_o    (fifo_rd_o),
    .noc_valid_o  (noc_valid_o),
    .noc_data_o   (noc_data_o),
    .noc_ready_i  (noc_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [FIFO_DW-1:0] mk(input logic h, input logic t,
                                            input logic [TIMERw-1:0] e,
                                            input logic [NOC_DATA_WIDTH-1:0] d);
    return {h, t, e, d};
  endfunction

  function automatic logic [63:0] accAt(input int i);
    return (i < acc.size()) ? 64'(acc[i]) : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  task automatic refresh();
    fifo_empty_i[0] = (q0.size() == 0);
    fifo_empty_i[1] = (q1.size() == 0);
    fifo_dat_i[0]   = (q0.size() != 0) ? q0[0] : '0;
    fifo_dat_i[1]   = (q1.size() != 0) ? q1[0] : '0;
  endtask

  task automatic applyStimulus(input int f, input logic [FIFO_DW-1:0] w);
    if (f == 0) q0.push_back(w);
    else        q1.push_back(w);
    refresh();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Each tick ends two time units after the rising edge with the timer advanced by one.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      timer_i = timer_i + 1'b1;
      #1;
    end
  endtask

  // Capture pop strobes and accepted flits mid-cycle, and watch for back-pressure violations.
  always @(negedge clk) begin
    rd_cap = fifo_rd_o;
    if ((fifo_rd_o & fifo_empty_i) != '0) bad_pops++;
    if (prev_stall && !(noc_valid_o && noc_data_o == prev_data)) hold_err++;
    if (noc_valid_o && noc_ready_i) acc.push_back(noc_data_o);
    prev_stall = noc_valid_o & ~noc_ready_i;
    prev_data  = noc_data_o;
  end

  // FIFO models: pop one cycle's captured strobes just after the edge.
  always @(posedge clk) begin
    #1;
    if (rd_cap[0] && q0.size() > 0) void'(q0.pop_front());
    if (rd_cap[1] && q1.size() > 0) void'(q1.pop_front());
    refresh();
  end

  initial begin
    rst         = 1'b1;
    timer_i     = '0;
    noc_ready_i = 1'b1;
    refresh();
    #2;
    checkOutput("reset_valid", 64'(noc_valid_o), 64'h0);
    checkOutput("reset_data",  64'(noc_data_o),  64'h0);
    checkOutput("reset_rd",    64'(fifo_rd_o),   64'h0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Single flit released exactly at its expiry time.
    timer_i = 10'd97;
    applyStimulus(0, mk(1'b1, 1'b1, 10'd100, 32'h0000_00A1));
    tick(2);
    checkOutput("t1_no_pop_at_99", 64'(fifo_rd_o), 64'h0);
    tick();
    checkOutput("t1_pop_at_100", 64'(fifo_rd_o), 64'h1);
    tick();
    checkOutput("t1_valid_at_101", 64'(noc_valid_o), 64'h1);
    checkOutput("t1_data_at_101",  64'(noc_data_o),  64'hA1);
    tick();
    checkOutput("t1_valid_cleared", 64'(noc_valid_o), 64'h0);
    checkOutput("t1_acc_count", 64'(acc.size()), 64'd1);

    // Timer wrap: F1 due at 0x3FE, F0 not due until 0x005.
    acc.delete();
    timer_i = 10'h3FC;
    applyStimulus(1, mk(1'b1, 1'b1, 10'h3FE, 32'h0000_00B2));
    applyStimulus(0, mk(1'b1, 1'b1, 10'h005, 32'h0000_00C3));
    tick();
    checkOutput("t2_no_pop_3fd", 64'(fifo_rd_o), 64'h0);
    tick();
    checkOutput("t2_pop_f1_3fe", 64'(fifo_rd_o), 64'h2);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("t2_no_pop_%0h", timer_i), 64'(fifo_rd_o), 64'h0);
    end
    tick();
    checkOutput("t2_pop_f0_005", 64'(fifo_rd_o), 64'h1);
    tick(2);
    checkOutput("t2_acc_count", 64'(acc.size()), 64'd2);
    checkOutput("t2_acc0", accAt(0), 64'hB2);
    checkOutput("t2_acc1", accAt(1), 64'hC3);

    // Simultaneous expiry after reset: FIFO0 packet first, then FIFO1, then next tie to FIFO0.
    rst = 1'b1;
    q0.delete();
    q1.delete();
    refresh();
    tick();
    rst = 1'b0;
    acc.delete();
    timer_i = 10'h050;
    applyStimulus(0, mk(1'b1, 1'b0, 10'h053, 32'h0000_0F0A));
    applyStimulus(0, mk(1'b0, 1'b0, 10'h000, 32'h0000_0F0B));
    applyStimulus(0, mk(1'b0, 1'b1, 10'h000, 32'h0000_0F0C));
    applyStimulus(1, mk(1'b1, 1'b0, 10'h053, 32'h0000_0F1A));
    applyStimulus(1, mk(1'b0, 1'b1, 10'h000, 32'h0000_0F1C));
    tick(10);
    checkOutput("t3_acc_count", 64'(acc.size()), 64'd5);
    checkOutput("t3_f0h", accAt(0), 64'hF0A);
    checkOutput("t3_f0b", accAt(1), 64'hF0B);
    checkOutput("t3_f0t", accAt(2), 64'hF0C);
    checkOutput("t3_f1h", accAt(3), 64'hF1A);
    checkOutput("t3_f1t", accAt(4), 64'hF1C);
    acc.delete();
    applyStimulus(0, mk(1'b1, 1'b1, timer_i, 32'h0000_00D0));
    applyStimulus(1, mk(1'b1, 1'b1, timer_i, 32'h0000_00D1));
    tick(4);
    checkOutput("t3_tie_count", 64'(acc.size()), 64'd2);
    checkOutput("t3_tie_first_f0", accAt(0), 64'hD0);
    checkOutput("t3_tie_second_f1", accAt(1), 64'hD1);

    // Back-pressure for five cycles in the middle of a packet.
    acc.delete();
    applyStimulus(0, mk(1'b1, 1'b0, timer_i, 32'h0000_00E0));
    applyStimulus(0, mk(1'b0, 1'b0, 10'h000, 32'h0000_00E1));
    applyStimulus(0, mk(1'b0, 1'b1, 10'h000, 32'h0000_00E2));
    tick();
    checkOutput("t4_head_out", 64'(noc_data_o), 64'hE0);
    noc_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("t4_hold_valid_%0d", i), 64'(noc_valid_o), 64'h1);
      checkOutput($sformatf("t4_hold_data_%0d", i),  64'(noc_data_o),  64'hE0);
      checkOutput($sformatf("t4_hold_no_pop_%0d", i), 64'(fifo_rd_o), 64'h0);
    end
    noc_ready_i = 1'b1;
    tick(4);
    checkOutput("t4_acc_count", 64'(acc.size()), 64'd3);
    checkOutput("t4_acc0", accAt(0), 64'hE0);
    checkOutput("t4_acc1", accAt(1), 64'hE1);
    checkOutput("t4_acc2", accAt(2), 64'hE2);

    // Locked FIFO0 runs dry after its head; FIFO1 waits for the FIFO0 tail.
    acc.delete();
    applyStimulus(0, mk(1'b1, 1'b0, timer_i, 32'h0000_0C00));
    tick();
    applyStimulus(1, mk(1'b1, 1'b1, timer_i, 32'h0000_0C09));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t5_f1_waits_%0d", i), 64'(fifo_rd_o), 64'h0);
    end
    applyStimulus(0, mk(1'b0, 1'b1, 10'h000, 32'h0000_0C01));
    #1;
    checkOutput("t5_tail_pop", 64'(fifo_rd_o), 64'h1);
    tick();
    checkOutput("t5_f1_granted", 64'(fifo_rd_o), 64'h2);
    tick(3);
    checkOutput("t5_acc_count", 64'(acc.size()), 64'd3);
    checkOutput("t5_acc0", accAt(0), 64'hC00);
    checkOutput("t5_acc1", accAt(1), 64'hC01);
    checkOutput("t5_acc2", accAt(2), 64'hC09);

    // Reset in the middle of a FIFO0 packet, then a FIFO1 flit must go through.
    applyStimulus(0, mk(1'b1, 1'b0, timer_i, 32'h0000_0AA0));
    applyStimulus(0, mk(1'b0, 1'b0, 10'h000, 32'h0000_0AA1));
    applyStimulus(0, mk(1'b0, 1'b1, 10'h000, 32'h0000_0AA2));
    tick(2);
    checkOutput("t6_before_reset_data", 64'(noc_data_o), 64'hAA1);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    refresh();
    #1;
    checkOutput("t6_reset_valid", 64'(noc_valid_o), 64'h0);
    checkOutput("t6_reset_data",  64'(noc_data_o),  64'h0);
    checkOutput("t6_reset_rd",    64'(fifo_rd_o),   64'h0);
    tick();
    rst = 1'b0;
    acc.delete();
    applyStimulus(1, mk(1'b1, 1'b1, timer_i, 32'h0000_0BB1));
    tick(3);
    checkOutput("t6_acc_count", 64'(acc.size()), 64'd1);
    checkOutput("t6_acc0", accAt(0), 64'hBB1);

    checkOutput("pop_while_empty", 64'(bad_pops), 64'd0);
    checkOutput("hold_violations", 64'(hold_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
